gcd_engine_p: RTL and testbench
===============================

// Module: gcd_engine_p
// PURPOSE
//  Parametrised multi-mode GCD engine; next generation of the fixed 32-bit gcd unit.
//  Takes two unsigned operands on a start pulse and iterates to their greatest common divisor.
//  Supports two algorithms: subtractive (Euclid) and binary (Stein), selected per operation.
//  Returns the result with a one-cycle done pulse; sits behind the same start/done handshake used by the tb.
// PARAMETERS
//  WIDTH    32  operand/result width in bits (>=2)
//  CNT_W    16  width of the iteration counter (GCD_CYCLE_CNT_EN only)
// PORTS
//  clk      in   1        system clock, all logic on rising edge
//  reset    in   1        synchronous, active-high reset
//  start    in   1        request; sampled only in IDLE
//  mode     in   1        0 = subtractive, 1 = binary; sampled with start
//  a_in     in   WIDTH    operand A, sampled with start
//  b_in     in   WIDTH    operand B, sampled with start
//  busy     out  1        high from the cycle after start until the cycle done is asserted
//  done     out  1        one-cycle pulse, result valid
//  result   out  WIDTH    GCD; holds until the next operation completes
//  cycles   out  CNT_W    CALC-cycle count of last operation (GCD_CYCLE_CNT_EN only)
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, result=0, cycles=0, internal regs=0; applies mid-operation (abort, no done).
//  States: IDLE -> CALC -> (binary: FIX) -> DONE -> IDLE.
//  IDLE: start=1 latches a_in, b_in, mode; clears k; next state CALC. start=0 stays IDLE.
//  start while busy/DONE: ignored, no queueing.
//  CALC entry zero rule: a==0 -> result=b; b==0 -> result=a (both 0 -> 0); go DONE after that one cycle.
//  Subtractive, each CALC cycle: a==b -> go DONE, result=a; a>b -> a<=a-b; else b<=b-a.
//  Binary, each CALC cycle, first match wins: a==b -> go FIX;
//   both even -> a>>=1, b>>=1, k++; a even -> a>>=1; b even -> b>>=1; a>b -> a<=a-b; else b<=b-a.
//  FIX (binary only, 1 cycle): result <= a << k; go DONE. k width = $clog2(WIDTH)+1.
//  DONE (1 cycle): done=1, busy=0; next IDLE. A start asserted in that same cycle is ignored.
//  Back-to-back: start in the first IDLE cycle after DONE is accepted.
//  Latency: start edge -> done = CALC iterations + 2 (subtractive) or + 3 (binary).
//   Subtractive worst case: operands (2^WIDTH-1, 1) give ~2^WIDTH iterations; no internal timeout.
//  All arithmetic unsigned WIDTH bits; subtraction never underflows by construction.
// CONFIGURATION
//  GCD_CYCLE_CNT_EN defined: port cycles present.
//   Counter is cleared on start accept and incremented each CALC cycle.
//   It saturates at all-ones and is registered to cycles when done is asserted.
//  Undefined: no cycles port, no counter logic; all other behaviour identical.
// STRUCTURE
//  gcd_pkg: typedef enum gcd_state_e {IDLE,CALC,FIX,DONE}; typedef enum gcd_mode_e {GCD_SUB,GCD_BIN};
//   Also holds a localparam default width.
//  Sub-module gcd_step: combinational single-iteration datapath (a,b,k,mode -> a',b',k',eq).
//   Instanced once; the FSM, operand registers and counter live in gcd_engine_p.
// TESTING
//  mode=0, a=48, b=18 -> done after 5 CALC cycles, result=6, busy low in done cycle.
//  mode=1, a=48, b=18 -> result=6 via FIX (k=1); cycles=7 with GCD_CYCLE_CNT_EN.
//  a=0, b=35 (both modes) -> result=35 one CALC cycle; a=0, b=0 -> result=0.
//  a=b=17 -> result=17 after 1 CALC cycle; mode=1 a=b=64 -> result=64.
//  start during busy with a=9, b=3 -> ignored, original result unchanged; reset mid-CALC -> IDLE, no done, result=0.
//  WIDTH=8: 300 random pairs in both modes vs reference model; start held high through DONE -> exactly one op per IDLE.

Source files
------------

// File: rtl/gcd_engine_p_pkg.sv
// Shared types and defaults for the multi-mode GCD engine.
// States and algorithm selectors used by gcd_engine_p and its datapath step.
package gcd_pkg;

    // Default operand/result width of the engine.
    localparam int GCD_DEFAULT_WIDTH = 32;

    // Default width of the optional iteration counter.
    localparam int GCD_DEFAULT_CNT_W = 16;

    // Engine control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } gcd_state_e;

    // Algorithm selector: subtractive Euclid or binary Stein.
    typedef enum logic {
        GCD_SUB = 1'b0,
        GCD_BIN = 1'b1
    } gcd_mode_e;

    // Width of the common power-of-two shift counter for a given operand width.
    function automatic int gcd_k_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/gcd_engine_p_step.sv
// Single-iteration GCD datapath (purely combinational).
// Given the current operand pair, the shared power-of-two count k and the
// algorithm, produces the operand pair and k for the next CALC cycle plus
// the termination flags. Operands are held unchanged once they are equal
// or either one is zero, so the controller can decide what to do next.
module gcd_step
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_DEFAULT_WIDTH,
    parameter int K_W   = gcd_k_width(GCD_DEFAULT_WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [K_W-1:0]   k,
    input  gcd_mode_e        mode,
    output logic [WIDTH-1:0] a_next,
    output logic [WIDTH-1:0] b_next,
    output logic [K_W-1:0]   k_next,
    output logic             eq,
    output logic             zero
);

    logic a_even_s;
    logic b_even_s;

    assign a_even_s = ~a[0];
    assign b_even_s = ~b[0];

    // One algorithm iteration; the first matching rule wins.
    always_comb begin
        a_next = a;
        b_next = b;
        k_next = k;
        eq     = (a == b);
        zero   = (a == {WIDTH{1'b0}}) || (b == {WIDTH{1'b0}});
        if (zero || eq) begin
            // Terminal pair: controller takes the result, operands hold.
            a_next = a;
            b_next = b;
        end else if (mode == GCD_BIN) begin
            if (a_even_s && b_even_s) begin
                a_next = a >> 1'b1;
                b_next = b >> 1'b1;
                k_next = k + {{(K_W-1){1'b0}}, 1'b1};
            end else if (a_even_s) begin
                a_next = a >> 1'b1;
            end else if (b_even_s) begin
                b_next = b >> 1'b1;
            end else if (a > b) begin
                a_next = a - b;
            end else begin
                b_next = b - a;
            end
        end else begin
            // Subtractive: larger minus smaller, never underflows.
            if (a > b) begin
                a_next = a - b;
            end else begin
                b_next = b - a;
            end
        end
    end

endmodule

// File: rtl/gcd_engine_p.sv
// Parametrised multi-mode GCD engine (subtractive Euclid / binary Stein).
// A start pulse in IDLE latches both operands and the algorithm; the engine
// iterates in CALC, applies the common power of two in FIX (binary only) and
// reports the result with a one-cycle done pulse.
// Optional build macro GCD_CYCLE_CNT_EN: adds the 'cycles' port reporting the
// number of CALC cycles of the last operation (saturating counter).
module gcd_engine_p
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_DEFAULT_WIDTH,
    parameter int CNT_W = GCD_DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
`ifdef GCD_CYCLE_CNT_EN
    ,
    output logic [CNT_W-1:0] cycles
`endif
);

    localparam int K_W = gcd_k_width(WIDTH);

    // Reject meaningless configurations at elaboration time.
    if (WIDTH < 2 || CNT_W < 1) begin : g_bad_params
        $error("gcd_engine_p: WIDTH must be >= 2 and CNT_W >= 1");
    end

    gcd_state_e       state_r;
    gcd_state_e       next_state_s;
    logic             accept_s;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [K_W-1:0]   k_r;
    gcd_mode_e        mode_r;

    logic [WIDTH-1:0] a_next_s;
    logic [WIDTH-1:0] b_next_s;
    logic [K_W-1:0]   k_next_s;
    logic             eq_s;
    logic             zero_s;

    logic [WIDTH-1:0] result_r;
    logic             busy_r;
    logic             done_r;

    gcd_step #(
        .WIDTH (WIDTH),
        .K_W   (K_W)
    ) u_step (
        .a      (a_r),
        .b      (b_r),
        .k      (k_r),
        .mode   (mode_r),
        .a_next (a_next_s),
        .b_next (b_next_s),
        .k_next (k_next_s),
        .eq     (eq_s),
        .zero   (zero_s)
    );

    // Control state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; start is only honoured in IDLE, never queued.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = CALC;
                    accept_s     = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            CALC: begin
                if (zero_s) begin
                    // A zero operand settles the answer immediately, no shift needed.
                    next_state_s = DONE;
                end else if (eq_s) begin
                    next_state_s = (mode_r == GCD_BIN) ? FIX : DONE;
                end else begin
                    next_state_s = CALC;
                end
            end
            FIX: begin
                next_state_s = DONE;
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Operand, shift-count and mode registers: load on accept, iterate in CALC.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r    <= {WIDTH{1'b0}};
            b_r    <= {WIDTH{1'b0}};
            k_r    <= {K_W{1'b0}};
            mode_r <= GCD_SUB;
        end else if (accept_s) begin
            a_r    <= a_in;
            b_r    <= b_in;
            k_r    <= {K_W{1'b0}};
            mode_r <= gcd_mode_e'(mode);
        end else if (state_r == CALC) begin
            a_r    <= a_next_s;
            b_r    <= b_next_s;
            k_r    <= k_next_s;
        end else begin
            a_r    <= a_r;
            b_r    <= b_r;
            k_r    <= k_r;
        end
    end

    // Result register; holds the last answer until a new one is produced.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_r <= {WIDTH{1'b0}};
        end else if (state_r == CALC && zero_s) begin
            result_r <= (a_r == {WIDTH{1'b0}}) ? b_r : a_r;
        end else if (state_r == CALC && eq_s && mode_r == GCD_SUB) begin
            result_r <= a_r;
        end else if (state_r == FIX) begin
            result_r <= a_r << k_r;
        end else begin
            result_r <= result_r;
        end
    end

    // Registered handshake outputs derived from the upcoming state.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (next_state_s == CALC) || (next_state_s == FIX);
            done_r <= (next_state_s == DONE);
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

`ifdef GCD_CYCLE_CNT_EN
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic [CNT_W-1:0] cycles_r;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Next count: cleared on accept, bumped for every CALC cycle.
    always_comb begin
        cnt_next_s = cnt_r;
        if (accept_s) begin
            cnt_next_s = {CNT_W{1'b0}};
        end else if (state_r == CALC) begin
            cnt_next_s = sat_inc(cnt_r);
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Running counter and the snapshot published alongside done.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r    <= {CNT_W{1'b0}};
            cycles_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_next_s;
            if (next_state_s == DONE) begin
                cycles_r <= cnt_next_s;
            end else begin
                cycles_r <= cycles_r;
            end
        end
    end

    assign cycles = cycles_r;
`else
    // No iteration counter in this build.
`endif

endmodule

// File: tb/tb_gcd_engine_p.sv
// Scoreboard bench for gcd_engine_p (WIDTH=8): directed corner cases plus
// randomized operand pairs in both modes against a behavioural reference.
module tb_gcd_engine_p;

    localparam int W  = 8;
    localparam int CW = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         mode;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
`ifdef GCD_CYCLE_CNT_EN
    logic [CW-1:0] cycles;
`endif

    gcd_engine_p #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mode   (mode),
        .a_in   (a_in),
        .b_in   (b_in),
        .busy   (busy),
        .done   (done),
        .result (result)
`ifdef GCD_CYCLE_CNT_EN
        ,
        .cycles (cycles)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int res;
        int done_cyc;
        int n;
    } exp_t;

    exp_t q[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   done_count = 0;

    // Greatest common divisor by the remainder form of Euclid.
    function automatic int ref_gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Number of CALC cycles the algorithm rules take, including the final one.
    function automatic int ref_iters(input int m, input int a, input int b);
        int n;
        n = 0;
        if (a == 0 || b == 0) return 1;
        while (a != b) begin
            n++;
            if (m == 1 && a % 2 == 0 && b % 2 == 0) begin
                a = a / 2;
                b = b / 2;
            end else if (m == 1 && a % 2 == 0) begin
                a = a / 2;
            end else if (m == 1 && b % 2 == 0) begin
                b = b / 2;
            end else if (a > b) begin
                a = a - b;
            end else begin
                b = b - a;
            end
        end
        return n + 1;
    endfunction

    // Edges from the accepting edge until done is presented.
    function automatic int ref_latency(input int m, input int a, input int b);
        return ref_iters(m, a, b) + ((m == 1 && a != 0 && b != 0) ? 1 : 0);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int m, input int a, input int b, input int base);
        exp_t e;
        e.res      = ref_gcd(a, b);
        e.n        = ref_iters(m, a, b);
        e.done_cyc = base + ref_latency(m, a, b);
        q.push_back(e);
    endtask

    // Waits (bounded) for all outstanding operations, then one idle cycle.
    task automatic wait_idle();
        int t;
        t = 0;
        while (q.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            check("timeout_pending_ops", q.size(), 0);
            q.delete();
        end
        @(negedge clk);
    endtask

    // Issues one start pulse from an IDLE negedge.
    task automatic issue(input int m, input int a, input int b, input bit expect_done);
        mode  = m[0];
        a_in  = a[W-1:0];
        b_in  = b[W-1:0];
        start = 1'b1;
        if (expect_done) push_exp(m, a, b, cyc + 1);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    // Monitor: every done pulse must match the oldest expected operation.
    always @(negedge clk) begin
        if (!reset && done) begin
            done_count++;
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got result %0d expected no done (t=%0t)", result, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("result", result, e.res);
                check("done_latency", cyc, e.done_cyc);
                check("busy_in_done", busy, 0);
`ifdef GCD_CYCLE_CNT_EN
                check("cycles", cycles, e.n);
`endif
            end
        end
    end

    int dm[11] = '{0, 1, 0, 1, 0, 1, 0, 1, 1, 0, 1};
    int da[11] = '{48, 48, 0, 0, 0, 0, 17, 17, 64, 255, 255};
    int db[11] = '{18, 18, 35, 35, 0, 0, 17, 17, 64, 1, 1};

    initial begin
        int snap;
        int seen;
        int lat;
        int base;
        int t;

        reset = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
`ifdef GCD_CYCLE_CNT_EN
        check("reset_cycles", cycles, 0);
`endif
        reset = 1'b0;
        @(negedge clk);

        // Directed corner cases.
        for (int i = 0; i < 11; i++) begin
            wait_idle();
            issue(dm[i], da[i], db[i], 1'b1);
        end

        // Start while busy must be ignored.
        wait_idle();
        issue(0, 48, 18, 1'b1);
        @(negedge clk);
        start = 1'b1;
        a_in  = 8'd9;
        b_in  = 8'd3;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        check("ignored_start_result", result, 6);

        // Reset in the middle of a long subtractive run aborts without done.
        wait_idle();
        issue(0, 200, 1, 1'b0);
        repeat (10) @(negedge clk);
        snap  = done_count;
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        reset = 1'b0;
        repeat (260) @(negedge clk);
        check("abort_no_done", done_count, snap);

        // Start held high: one operation per IDLE, back-to-back.
        wait_idle();
        lat   = ref_latency(1, 48, 18);
        base  = cyc + 1;
        mode  = 1'b1;
        a_in  = 8'd48;
        b_in  = 8'd18;
        start = 1'b1;
        for (int j = 0; j < 3; j++) begin
            exp_t e;
            e.res      = 6;
            e.n        = ref_iters(1, 48, 18);
            e.done_cyc = base + lat + j * (lat + 2);
            q.push_back(e);
        end
        snap = done_count;
        seen = 0;
        t    = 0;
        while (seen < 3 && t < 200) begin
            @(negedge clk);
            t++;
            if (done) seen++;
        end
        start = 1'b0;
        wait_idle();
        repeat (20) @(negedge clk);
        check("held_start_ops", done_count - snap, 3);

        // Randomized pairs in both modes.
        for (int i = 0; i < 300; i++) begin
            for (int m = 0; m < 2; m++) begin
                wait_idle();
                issue(m, $urandom_range(0, 255), $urandom_range(0, 255), 1'b1);
            end
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
